// File: rtl/mux_rr_pipe_if.sv
// Handshake/bus bundle for mux_rr_pipe.
//   in_data   : N packed channels, channel k at [k*W +: W]
//   in_valid  : per-channel offer
//   in_ack    : one-hot acknowledge of the channel captured this cycle
//   mode      : 0 = direct select by op, 1 = round-robin scan
//   op        : direct-mode channel index
//   out_data  : registered selected word
//   out_chan  : channel index of out_data
//   out_valid : out_data/out_chan hold an unconsumed word
//   out_ready : consumer accepts when out_valid && out_ready
//   sel_err   : sticky illegal direct-select flag
// master = producer/consumer side, slave = the mux.
interface mux_rr_pipe_if #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 8,
    parameter int unsigned SELW = 3
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ack;
    logic            mode;
    logic [SELW-1:0] op;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_chan;
    logic            out_valid;
    logic            out_ready;
    logic            sel_err;

    modport master (
        output in_data, in_valid, mode, op, out_ready,
        input  in_ack, out_data, out_chan, out_valid, sel_err
    );

    modport slave (
        input  in_data, in_valid, mode, op, out_ready,
        output in_ack, out_data, out_chan, out_valid, sel_err
    );
endinterface

// File: rtl/mux_rr_pipe.sv
// N-channel mux with direct or round-robin selection into a one-word
// registered output stage with valid/ready flow control.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux_rr_pipe_if slave (inputs, acks, registered output, sel_err)
module mux_rr_pipe #(
    parameter int unsigned W    = 8,
    parameter int unsigned N    = 8,
    parameter int unsigned SELW = 3
) (
    input logic         clk,
    input logic         rst_n,
    mux_rr_pipe_if.slave bus
);

    logic [W-1:0]    data_q;
    logic [SELW-1:0] chan_q;
    logic [SELW-1:0] ptr_q;
    logic            valid_q;
    logic            err_q;

    logic            can_load;
    logic            op_ok;
    logic            dir_hit;
    logic            rr_hit;
    logic [SELW-1:0] rr_idx;
    logic            cap;
    logic [SELW-1:0] cap_idx;
    logic [W-1:0]    cap_data;
    logic [N-1:0]    ack;

    // Direct mode: op in range and that channel is offering.
    always_comb begin
        op_ok   = 32'(bus.op) < N;
        dir_hit = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (SELW'(k) == bus.op && bus.in_valid[k]) begin
                dir_hit = 1'b1;
            end
        end
    end

    // Round-robin: first valid channel after ptr, wrapping, ptr itself last.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!rr_hit && bus.in_valid[SELW'(idx)]) begin
                rr_hit = 1'b1;
                rr_idx = SELW'(idx);
            end
        end
    end

    // Capture decision, one-hot acknowledge and data select.
    always_comb begin
        can_load = !valid_q || bus.out_ready;
        cap      = 1'b0;
        cap_idx  = '0;
        ack      = '0;
        cap_data = '0;
        if (rst_n && can_load) begin
            if (!bus.mode) begin
                if (op_ok && dir_hit) begin
                    cap     = 1'b1;
                    cap_idx = bus.op;
                end
            end else if (rr_hit) begin
                cap     = 1'b1;
                cap_idx = rr_idx;
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (SELW'(k) == cap_idx) begin
                ack[k]   = cap;
                cap_data = bus.in_data[k*W +: W];
            end
        end
    end

    // Output stage, round-robin pointer and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= SELW'(N - 1);
        end else begin
            if (cap) begin
                data_q  <= cap_data;
                chan_q  <= cap_idx;
                valid_q <= 1'b1;
                if (bus.mode) begin
                    ptr_q <= cap_idx;
                end
            end else if (can_load) begin
                valid_q <= 1'b0;
            end
            if (!bus.mode && !op_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ack    = ack;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Randomized self-checking bench for mux_rr_pipe (N=8) with a transaction-level
// reference model, plus directed checks on an N=6 instance for illegal selects.
module tb_mux_rr_pipe;
    localparam int unsigned W    = 8;
    localparam int unsigned N    = 8;
    localparam int unsigned SELW = 3;
    localparam int unsigned N6   = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic rst6_n;

    always #5 clk = ~clk;

    mux_rr_pipe_if #(.W(W), .N(N),  .SELW(SELW)) bus  ();
    mux_rr_pipe_if #(.W(W), .N(N6), .SELW(SELW)) bus6 ();

    mux_rr_pipe #(.W(W), .N(N), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mux_rr_pipe #(.W(W), .N(N6), .SELW(SELW)) dut6 (
        .clk   (clk),
        .rst_n (rst6_n),
        .bus   (bus6.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    logic         m_err;
    logic [N-1:0] last_ack;
    logic [W-1:0] exp_hold;

    // Channel that should be captured this cycle, -1 for none.
    function automatic int model_pick();
        int k;
        if (!rst_n) return -1;
        if (m_valid && !bus.out_ready) return -1;
        if (!bus.mode) begin
            if (int'(bus.op) < int'(N) && bus.in_valid[bus.op]) return int'(bus.op);
            return -1;
        end
        for (int d = 1; d <= int'(N); d++) begin
            k = (m_ptr + d) % int'(N);
            if (bus.in_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ack();
        logic [N-1:0] a;
        int p;
        a = '0;
        p = model_pick();
        if (p >= 0) a[p] = 1'b1;
        return a;
    endfunction

    task automatic model_update();
        int p;
        p = model_pick();
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_err   = 1'b0;
            m_ptr   = int'(N) - 1;
        end else begin
            if (p >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[p*W +: W];
                m_chan  = p;
                if (bus.mode) m_ptr = p;
            end else if (!m_valid || bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (!bus.mode && int'(bus.op) >= int'(N)) m_err = 1'b1;
        end
    endtask

    // One clock of the main instance: inputs already driven after a falling edge.
    task automatic tick();
        logic [N-1:0] ea;
        #1;
        ea       = model_ack();
        last_ack = bus.in_ack;
        check("ack", 32'(bus.in_ack), 32'(ea));
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data",  32'(bus.out_data),  32'(m_data));
        check("out_chan",  32'(bus.out_chan),  32'(m_chan));
        check("sel_err",   32'(bus.sel_err),   32'(m_err));
    endtask

    task automatic rand_inputs();
        bus.in_data = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0:       bus.in_valid = '0;
            1:       bus.in_valid = N'($urandom() & $urandom() & $urandom());
            default: bus.in_valid = N'($urandom());
        endcase
        bus.mode      = ($urandom_range(0, 3) != 0);
        bus.op        = SELW'($urandom());
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic tick6();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst6_n = 1'b0;
        bus.in_data  = '0; bus.in_valid  = '0; bus.mode  = 1'b0; bus.op  = '0; bus.out_ready  = 1'b1;
        bus6.in_data = '0; bus6.in_valid = '0; bus6.mode = 1'b0; bus6.op = '0; bus6.out_ready = 1'b1;
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = 0; m_err = 1'b0;
        last_ack = '0; exp_hold = '0;

        // ---- N=6 instance: illegal op, sticky error, reset clears, RR restarts at 0
        @(negedge clk);
        bus6.in_data  = {$urandom(), $urandom()};
        bus6.in_valid = 6'h3F;
        bus6.op       = 3'd7;
        tick6();
        rst6_n = 1'b1;
        check("n6_rst_valid", 32'(bus6.out_valid), 32'd0);
        check("n6_rst_err",   32'(bus6.sel_err),   32'd0);
        #1;
        check("n6_badop_ack", 32'(bus6.in_ack), 32'h0);
        tick6();
        check("n6_badop_valid", 32'(bus6.out_valid), 32'd0);
        check("n6_badop_err",   32'(bus6.sel_err),   32'd1);
        bus6.op = 3'd2;
        #1;
        check("n6_op2_ack", 32'(bus6.in_ack), 32'h04);
        tick6();
        check("n6_op2_chan",  32'(bus6.out_chan),  32'd2);
        check("n6_op2_data",  32'(bus6.out_data),  32'(bus6.in_data[2*W +: W]));
        check("n6_err_sticky", 32'(bus6.sel_err),  32'd1);
        rst6_n = 1'b0;
        #1;
        check("n6_ack_in_rst", 32'(bus6.in_ack), 32'h0);
        tick6();
        rst6_n = 1'b1;
        check("n6_rst2_err",   32'(bus6.sel_err),   32'd0);
        check("n6_rst2_valid", 32'(bus6.out_valid), 32'd0);
        check("n6_rst2_data",  32'(bus6.out_data),  32'd0);
        bus6.mode = 1'b1;
        #1;
        check("n6_rr_first_ack", 32'(bus6.in_ack), 32'h01);
        tick6();
        check("n6_rr_first_chan", 32'(bus6.out_chan), 32'd0);
        #1;
        check("n6_rr_second_ack", 32'(bus6.in_ack), 32'h02);
        tick6();
        check("n6_rr_second_chan", 32'(bus6.out_chan), 32'd1);
        bus6.in_valid = 6'h21;
        tick6();
        check("n6_wrap_a", 32'(bus6.out_chan), 32'd5);
        tick6();
        check("n6_wrap_b", 32'(bus6.out_chan), 32'd0);

        // ---- main instance: reset
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_chan",  32'(bus.out_chan),  32'd0);
        rst_n = 1'b1;

        // Direct select of channel 5
        bus.mode = 1'b0; bus.op = 3'd5; bus.in_valid = 8'h20; bus.out_ready = 1'b1;
        bus.in_data = {$urandom(), $urandom()};
        bus.in_data[5*W +: W] = 8'hA5;
        tick();
        check("d5_ack",   32'(last_ack),      32'h20);
        check("d5_data",  32'(bus.out_data),  32'hA5);
        check("d5_chan",  32'(bus.out_chan),  32'd5);
        check("d5_valid", 32'(bus.out_valid), 32'd1);

        // Full round-robin sweep at full throughput
        bus.mode = 1'b1; bus.in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            bus.in_data = {$urandom(), $urandom()};
            if (i == 8) exp_hold = bus.in_data[0 +: W];
            tick();
            check("rr_seq_chan",  32'(bus.out_chan),  32'(i % 8));
            check("rr_seq_valid", 32'(bus.out_valid), 32'd1);
        end

        // Backpressure for three cycles with changing inputs
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = {$urandom(), $urandom()};
            bus.in_valid = N'($urandom()) | 8'h01;
            bus.mode     = 1'($urandom());
            bus.op       = SELW'($urandom());
            tick();
            check("bp_ack",   32'(last_ack),      32'h0);
            check("bp_data",  32'(bus.out_data),  32'(exp_hold));
            check("bp_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1; bus.mode = 1'b1; bus.in_valid = 8'h08;
        bus.in_data = {$urandom(), $urandom()};
        tick();
        check("bp_release_ack",   32'(last_ack),      32'h08);
        check("bp_release_chan",  32'(bus.out_chan),  32'd3);
        check("bp_release_valid", 32'(bus.out_valid), 32'd1);

        // Wrap-around from ptr=6 with channels 0 and 6 valid
        bus.in_valid = 8'h40;
        tick();
        check("wrap_setup", 32'(bus.out_chan), 32'd6);
        bus.in_valid = 8'h41;
        tick();
        check("wrap_a", 32'(bus.out_chan), 32'd0);
        tick();
        check("wrap_b", 32'(bus.out_chan), 32'd6);
        tick();
        check("wrap_c", 32'(bus.out_chan), 32'd0);

        // Randomized traffic with mode switches and occasional reset
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_rr_pipe.md
MUX_RR_PIPE -- requirements
Module: mux_rr_pipe

Interface
REQ-001 SHALL have parameter W, default 8: data width per channel in bits, at least 1.
REQ-002 SHALL have parameter N, default 8: channel count, from 2 to 16.
REQ-003 SHALL have parameter SELW, default 3: select/index width, equal to clog2(N).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_data, input, N*W bits: channel k occupies bits [k*W+W-1 : k*W].
REQ-007 SHALL have port in_valid, input, N bits: bit k high means channel k offers data.
REQ-008 SHALL have port in_ack, output, N bits: one-hot pulse marking the channel captured this cycle.
REQ-009 SHALL have port mode, input, 1 bit: 0 = direct select by op, 1 = round-robin scan.
REQ-010 SHALL have port op, input, SELW bits: channel index in direct mode; op=0 selects channel 0.
REQ-011 SHALL have port out_data, output, W bits: registered selected data.
REQ-012 SHALL have port out_chan, output, SELW bits: index of the channel held in out_data.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data/out_chan hold an unconsumed word.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the word when out_valid and out_ready are both high.
REQ-015 SHALL have port sel_err, output, 1 bit: sticky flag, set when direct mode selects op >= N.

Function
REQ-016 SHALL define can_load = !out_valid || out_ready.
REQ-017 Direct mode: on an edge where can_load is high, in_valid[op] is high and op < N, SHALL capture in_data channel op into out_data, write op to out_chan, set out_valid, and pulse in_ack[op] high during that same cycle (combinational acknowledge).
REQ-018 Round-robin mode: the candidate SHALL be the first k with in_valid[k] high, searching (ptr+1) mod N, (ptr+2) mod N, ... up to ptr, where ptr is the last granted index.
REQ-019 Round-robin mode: when can_load is high and any in_valid bit is high, SHALL capture the candidate, pulse its in_ack bit, and load ptr with that index.
REQ-020 ptr SHALL update only on a round-robin capture; it SHALL be held through direct-mode captures and idle cycles.
REQ-021 If can_load is high and no capture occurs, SHALL clear out_valid on the edge; out_data and out_chan SHALL hold their values.
REQ-022 If can_load is low, out_data, out_chan and out_valid SHALL hold, and in_ack SHALL be all zero (backpressure).
REQ-023 Simultaneous consume and capture in one cycle SHALL give full throughput: one word per cycle, with no bubble inserted.
REQ-024 Latency SHALL be one cycle from capture edge to out_valid high.
REQ-025 in_ack SHALL have at most one bit high in any cycle.
REQ-026 op >= N in direct mode SHALL cause no capture and SHALL set sel_err; sel_err SHALL clear only on reset.
REQ-027 A change of mode SHALL take effect on the very next edge; no capture SHALL be lost or duplicated across the change.
REQ-028 Wrap-around: the search SHALL continue from N-1 to 0; with only channel ptr valid, channel ptr SHALL be re-granted.

Reset
REQ-029 While rst_n is low at a rising edge, SHALL set out_valid=0, out_data=0, out_chan=0, sel_err=0 and ptr=N-1, so the first round-robin search starts at channel 0.
REQ-030 in_ack SHALL be all zero during any cycle in which rst_n is low.
REQ-031 Reset asserted mid-transfer SHALL discard the held word with no acknowledge.

Verification
REQ-032 Direct mode, W=8, N=8: op=5, in_valid=0x20, ch5=0xA5, out_ready=1 -> in_ack=0x20 that cycle; next cycle out_data=0xA5, out_chan=5, out_valid=1.
REQ-033 Round-robin with in_valid=0xFF held and out_ready=1 -> out_chan sequence 0,1,...,7,0 on consecutive cycles with out_valid continuously high.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles with inputs changing -> out_data stable, in_ack=0; after out_ready rises, the next word loads with no bubble.
REQ-035 Round-robin with ptr=6 and in_valid=0x41 -> grant channel 0, then channel 6, then channel 0 (wrap-around).
REQ-036 Direct mode, N=6: op=7 -> no capture, sel_err=1 sticky; rst_n low for 1 cycle -> sel_err=0, out_valid=0, and the next round-robin grant starts from channel 0.
